// File: rtl/luzes_pkg.sv
// ============================================================================
// luzes_pkg: shared state encoding, mode constants and pattern decode for the
// light sequencer. Rev 1.0
// ============================================================================
`default_nettype none

package luzes_pkg;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] LIMPAR   = 2'd1;
  localparam logic [1:0] EXECUTAR = 2'd2;

  localparam logic [1:0] MODO_CHASE = 2'b00;
  localparam logic [1:0] MODO_FILL  = 2'b01;
  localparam logic [1:0] MODO_BLINK = 2'b10;
  localparam logic [1:0] MODO_EXT   = 2'b11;

  localparam int TICK_DIV_PADRAO = 50_000_000;

  typedef struct packed {
    logic dado;
    logic desloca;
    logic limpa;
    logic enche;
  } pulsos_t;

  // Action for one pattern step, taken from the step index before it advances.
  function automatic pulsos_t acao_padrao(input logic [1:0] modo,
                                          input logic [2:0] passo,
                                          input logic       ext);
    pulsos_t p;
    p = '0;
    case (modo)
      MODO_CHASE: begin
        p.desloca = 1'b1;
        p.dado    = (passo[1:0] == 2'b00);
      end
      MODO_FILL: begin
        p.desloca = 1'b1;
        p.dado    = ~passo[2];
      end
      MODO_BLINK: begin
        if (passo[0] == 1'b0) p.enche = 1'b1;
        else                  p.limpa = 1'b1;
      end
      default: begin
        p.desloca = 1'b1;
        p.dado    = ext;
      end
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_tick.sv
// ============================================================================
// divisor_tick: prescaler counting 0..DIV-1 while enabled; one-cycle tick on
// the last count. Rev 1.0
// ============================================================================
`default_nettype none

module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clock_placa,
  input  logic reset,
  input  logic habilita,
  input  logic zera,
  output logic tick
);

  localparam int                 LARGURA  = $clog2(DIV);
  localparam logic [LARGURA-1:0] C_ULTIMO = LARGURA'(DIV - 1);
  localparam logic [LARGURA-1:0] C_UM     = LARGURA'(1);

  logic [LARGURA-1:0] r_cont;

  always_ff @(posedge clock_placa or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (zera) begin
      r_cont <= '0;
    end else if (habilita) begin
      r_cont <= (r_cont == C_ULTIMO) ? '0 : r_cont + C_UM;
    end
  end

  // Gated by habilita so a frozen count never produces a tick.
  assign tick = habilita && (r_cont == C_ULTIMO);

endmodule

`default_nettype wire

// File: rtl/sequenciador_luzes.sv
// ============================================================================
// sequenciador_luzes: drives shift/clear/preset/data of the 4-bit light shift
// register with four selectable patterns. Rev 1.0
// ============================================================================
`default_nettype none

module sequenciador_luzes
  import luzes_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_PADRAO
) (
  input  logic       clock_placa,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       pausa,
  input  logic [1:0] modo,
  input  logic       entrada_ext,
  output logic       dado,
  output logic       desloca,
  output logic       limpa,
  output logic       enche,
  output logic       ativo,
  output logic [2:0] passo
);

  logic [1:0] r_rst_sinc;
  logic       w_reset_int;
  logic [1:0] r_estado;
  logic [1:0] w_prox;
  logic [1:0] r_modo;
  logic [2:0] r_passo;
  logic [1:0] r_ext_sinc;
  logic       w_tick;
  logic       w_avanca;
  logic       w_entra_limpar;
  pulsos_t    w_pulsos;
  logic       w_ativo;

  // Assert immediately, release on a clock edge.
  always_ff @(posedge clock_placa or negedge reset) begin
    if (!reset) r_rst_sinc <= 2'b00;
    else        r_rst_sinc <= {r_rst_sinc[0], 1'b1};
  end
  assign w_reset_int = r_rst_sinc[1];

  always_ff @(posedge clock_placa or negedge w_reset_int) begin
    if (!w_reset_int) r_estado <= OCIOSO;
    else              r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (iniciar && !parar) w_prox = LIMPAR;
      LIMPAR:   w_prox = parar ? OCIOSO : EXECUTAR;
      EXECUTAR: if (parar) w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  assign w_entra_limpar = (w_prox == LIMPAR);

  divisor_tick #(
    .DIV(TICK_DIV)
  ) u_divisor (
    .clock_placa(clock_placa),
    .reset      (w_reset_int),
    .habilita   ((r_estado == EXECUTAR) && !pausa),
    .zera       (w_entra_limpar),
    .tick       (w_tick)
  );

  // A tick that coincides with a stop request is dropped.
  assign w_avanca = w_tick && (w_prox == EXECUTAR);

  always_comb begin
    w_pulsos = '0;
    w_ativo  = (w_prox != OCIOSO);
    if (w_entra_limpar) w_pulsos.limpa = 1'b1;
    else if (w_avanca)  w_pulsos = acao_padrao(r_modo, r_passo, r_ext_sinc[1]);
  end

  always_ff @(posedge clock_placa or negedge w_reset_int) begin
    if (!w_reset_int) begin
      r_passo <= 3'd0;
      r_modo  <= MODO_CHASE;
    end else if (w_entra_limpar) begin
      r_passo <= 3'd0;
      r_modo  <= modo;
    end else if (w_avanca) begin
      r_passo <= r_passo + 3'd1;
    end
  end

  always_ff @(posedge clock_placa or negedge w_reset_int) begin
    if (!w_reset_int) r_ext_sinc <= 2'b00;
    else              r_ext_sinc <= {r_ext_sinc[0], entrada_ext};
  end

  always_ff @(posedge clock_placa or negedge w_reset_int) begin
    if (!w_reset_int) begin
      dado    <= 1'b0;
      desloca <= 1'b0;
      limpa   <= 1'b0;
      enche   <= 1'b0;
      ativo   <= 1'b0;
    end else begin
      dado    <= w_pulsos.dado;
      desloca <= w_pulsos.desloca;
      limpa   <= w_pulsos.limpa;
      enche   <= w_pulsos.enche;
      ativo   <= w_ativo;
    end
  end

  assign passo = r_passo;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_luzes.sv
// ============================================================================
// tb_sequenciador_luzes: directed table-driven bench for sequenciador_luzes
// with TICK_DIV=4. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sequenciador_luzes;

  logic       clock_placa = 1'b0;
  logic       reset       = 1'b0;
  logic       iniciar     = 1'b0;
  logic       parar       = 1'b0;
  logic       pausa       = 1'b0;
  logic [1:0] modo        = 2'b00;
  logic       entrada_ext = 1'b0;
  logic       dado, desloca, limpa, enche, ativo;
  logic [2:0] passo;
  logic [7:0] saidas;

  int checks = 0;
  int errors = 0;

  sequenciador_luzes #(
    .TICK_DIV(4)
  ) dut (
    .clock_placa(clock_placa),
    .reset      (reset),
    .iniciar    (iniciar),
    .parar      (parar),
    .pausa      (pausa),
    .modo       (modo),
    .entrada_ext(entrada_ext),
    .dado       (dado),
    .desloca    (desloca),
    .limpa      (limpa),
    .enche      (enche),
    .ativo      (ativo),
    .passo      (passo)
  );

  always #5 clock_placa = ~clock_placa;

  // {dado, desloca, limpa, enche, ativo, passo[2:0]}
  assign saidas = {dado, desloca, limpa, enche, ativo, passo};

  typedef struct {
    logic       iniciar;
    logic       parar;
    logic       pausa;
    logic [1:0] modo;
    int         ciclos;
    logic [7:0] esperado;
  } vetor_t;

  vetor_t tabela[$];

  task automatic add(input logic ini, input logic par, input logic pau,
                     input logic [1:0] m, input int c,
                     input logic d, input logic dl, input logic lp,
                     input logic en, input logic at, input logic [2:0] p);
    vetor_t v;
    v.iniciar  = ini;
    v.parar    = par;
    v.pausa    = pau;
    v.modo     = m;
    v.ciclos   = c;
    v.esperado = {d, dl, lp, en, at, p};
    tabela.push_back(v);
  endtask

  task automatic checar(input string nome, input logic [7:0] atual,
                        input logic [7:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nome, atual, esperado);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    logic        hist[0:31];
    logic        exp_desl;

    // Chase: dado 1,0,0,0 repeating, passo wraps 7->0
    add(1, 0, 0, 2'd0, 1, 0, 0, 1, 0, 1, 3'd0);
    add(0, 0, 0, 2'd0, 4, 0, 0, 0, 0, 1, 3'd0);
    add(0, 0, 0, 2'd0, 1, 1, 1, 0, 0, 1, 3'd1);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 2'd0, 4, (k % 4 == 0), 1, 0, 0, 1, 3'((k + 1) % 8));
    add(0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 3'd1);
    // Fill with modo switched to blink mid-run (must be ignored)
    add(1, 0, 0, 2'd1, 1, 0, 0, 1, 0, 1, 3'd0);
    add(0, 0, 0, 2'd1, 4, 0, 0, 0, 0, 1, 3'd0);
    add(0, 0, 0, 2'd1, 1, 1, 1, 0, 0, 1, 3'd1);
    add(0, 0, 0, 2'd1, 4, 1, 1, 0, 0, 1, 3'd2);
    for (int k = 2; k <= 7; k++)
      add(0, 0, 0, 2'd2, 4, (k < 4), 1, 0, 0, 1, 3'((k + 1) % 8));
    add(0, 1, 0, 2'd2, 1, 0, 0, 0, 0, 0, 3'd0);
    // iniciar and parar together in OCIOSO
    add(1, 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 3'd0);
    add(0, 0, 0, 2'd0, 2, 0, 0, 0, 0, 0, 3'd0);
    // Blink with pause at count 2, then parar on a tick cycle
    add(1, 0, 0, 2'd2, 1, 0, 0, 1, 0, 1, 3'd0);
    add(0, 0, 0, 2'd2, 4, 0, 0, 0, 0, 1, 3'd0);
    add(0, 0, 0, 2'd2, 1, 0, 0, 0, 1, 1, 3'd1);
    add(0, 0, 0, 2'd2, 4, 0, 0, 1, 0, 1, 3'd2);
    add(0, 0, 0, 2'd2, 2, 0, 0, 0, 0, 1, 3'd2);
    add(0, 0, 1, 2'd2, 10, 0, 0, 0, 0, 1, 3'd2);
    add(0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 1, 3'd2);
    add(0, 0, 0, 2'd2, 1, 0, 0, 0, 1, 1, 3'd3);
    add(0, 0, 0, 2'd2, 4, 0, 0, 1, 0, 1, 3'd4);
    add(0, 0, 0, 2'd2, 3, 0, 0, 0, 0, 1, 3'd4);
    add(0, 1, 0, 2'd2, 1, 0, 0, 0, 0, 0, 3'd4);
    add(0, 0, 0, 2'd2, 2, 0, 0, 0, 0, 0, 3'd4);

    // Reset then idle
    reset = 1'b0;
    repeat (3) @(posedge clock_placa);
    #1;
    checar("reset state", saidas, 8'h00);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock_placa);
      #1;
      checar($sformatf("idle cycle %0d", c), saidas, 8'h00);
    end

    foreach (tabela[i]) begin
      iniciar = tabela[i].iniciar;
      parar   = tabela[i].parar;
      pausa   = tabela[i].pausa;
      modo    = tabela[i].modo;
      for (int c = 0; c < tabela[i].ciclos; c++) begin
        @(posedge clock_placa);
        #1;
        if (c < tabela[i].ciclos - 1)
          checar($sformatf("vec %0d quiet %0d", i, c),
                 {5'b0, desloca, limpa, enche}, 8'h00);
        else
          checar($sformatf("vec %0d", i), saidas, tabela[i].esperado);
      end
    end

    // External mode with iniciar held high, then asynchronous reset mid-run
    pat = 32'hB4E1_9A37;
    parar = 1'b0;
    pausa = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      iniciar     = 1'b1;
      modo        = 2'b11;
      entrada_ext = pat[i];
      hist[i]     = pat[i];
      @(posedge clock_placa);
      #1;
      exp_desl = (i >= 5) && ((i - 5) % 4 == 0);
      checar($sformatf("ext limpa %0d", i), {7'b0, limpa}, {7'b0, (i == 0)});
      checar($sformatf("ext desloca %0d", i), {6'b0, desloca, ativo},
             {6'b0, exp_desl, 1'b1});
      if (exp_desl)
        checar($sformatf("ext dado %0d", i), {7'b0, dado}, {7'b0, hist[i-2]});
    end
    #2;
    reset = 1'b0;
    #1;
    checar("async reset same cycle", saidas, 8'h00);
    iniciar = 1'b0;
    @(posedge clock_placa);
    #1;
    checar("held in reset", saidas, 8'h00);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock_placa);
      #1;
      checar($sformatf("after reset %0d", c), saidas, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
